// File: rtl/reference_buffer_sweeper.sv
// reference_buffer_sweeper
// Walks a contiguous, wrapping range of reference_buffer indices. Each index is
// requested on its own, the returned I/Q sample is captured and then offered on
// a registered output stream. The last sample of the sweep carries out_tlast.
//
// Ports:
//   clk, n_reset                 clock, synchronous active-low reset
//   start, base_index, sweep_len sweep request (sweep_len 0 = buffer_length)
//   busy, done, err              status (done/err are one-cycle pulses)
//   m_axis_index_*               index request towards the buffer
//   s_axis_data_tready           buffer accepts the index
//   m_axis_tready                sweeper accepts returned data
//   s_axis_data_tvalid, i, q     returned sample
//   out_tvalid/out_tready        output handshake
//   out_i, out_q, out_tlast      registered output sample
//
// state | meaning
// IDLE  | waiting for start
// REQ   | index offered, waiting for s_axis_data_tready
// WAIT  | index accepted, waiting for returned sample
// OUT   | sample held on output, waiting for out_tready
// FIN   | done pulse, back to IDLE
module reference_buffer_sweeper #(
  parameter int index_bits    = 8,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int buffer_length = 256
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic [index_bits-1:0] base_index,
  input  logic [index_bits-1:0] sweep_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  m_axis_index_tvalid,
  output logic [index_bits-1:0] m_axis_index_tdata,
  input  logic                  s_axis_data_tready,
  output logic                  m_axis_tready,
  input  logic                  s_axis_data_tvalid,
  input  logic [i_bits-1:0]     i,
  input  logic [q_bits-1:0]     q,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [i_bits-1:0]     out_i,
  output logic [q_bits-1:0]     out_q,
  output logic                  out_tlast
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, FIN} state_t;

  localparam logic [index_bits:0]   len_full = (index_bits+1)'(buffer_length);
  localparam logic [index_bits-1:0] last_idx = index_bits'(buffer_length - 1);

  state_t                state;
  logic [index_bits:0]   len;
  logic [index_bits:0]   count;
  logic [index_bits-1:0] nxt_idx;

  // m_axis_index_tdata doubles as the current index; it only changes when a
  // sweep starts or a sample has left the output, so it is stable in REQ.
  assign nxt_idx = (m_axis_index_tdata == last_idx) ? '0
                                                    : m_axis_index_tdata + index_bits'(1);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state               <= IDLE;
      len                 <= '0;
      count               <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
      m_axis_index_tvalid <= 1'b0;
      m_axis_index_tdata  <= '0;
      m_axis_tready       <= 1'b0;
      out_tvalid          <= 1'b0;
      out_i               <= '0;
      out_q               <= '0;
      out_tlast           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, base_index} >= len_full) begin
              err <= 1'b1;
            end else begin
              len                 <= (sweep_len == '0) ? len_full : {1'b0, sweep_len};
              count               <= '0;
              m_axis_index_tdata  <= base_index;
              m_axis_index_tvalid <= 1'b1;
              busy                <= 1'b1;
              state               <= REQ;
            end
          end
        end
        REQ: begin
          if (s_axis_data_tready) begin
            m_axis_index_tvalid <= 1'b0;
            m_axis_tready       <= 1'b1;
            state               <= WAIT;
          end
        end
        WAIT: begin
          if (s_axis_data_tvalid) begin
            m_axis_tready <= 1'b0;
            out_i         <= i;
            out_q         <= q;
            out_tvalid    <= 1'b1;
            out_tlast     <= (count == len - (index_bits+1)'(1));
            state         <= OUT;
          end
        end
        OUT: begin
          if (out_tready) begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            if (out_tlast) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              count               <= count + (index_bits+1)'(1);
              m_axis_index_tdata  <= nxt_idx;
              m_axis_index_tvalid <= 1'b1;
              state               <= REQ;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reference_buffer_sweeper.sv
// Bench for reference_buffer_sweeper with buffer_length=8. A behavioural buffer
// and downstream sink with configurable/random stalls drive the DUT; requested
// indices and output samples are collected and compared against the expected
// sweep computed directly from base and length.
module tb_reference_buffer_sweeper;
  localparam int IB = 8;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          n_reset, start, busy, done, err;
  logic [IB-1:0] base_index, sweep_len, m_axis_index_tdata;
  logic          m_axis_index_tvalid, s_axis_data_tready, m_axis_tready, s_axis_data_tvalid;
  logic [11:0]   i, q, out_i, out_q;
  logic          out_tvalid, out_tready, out_tlast;

  reference_buffer_sweeper #(.index_bits(IB), .i_bits(12), .q_bits(12), .buffer_length(BL)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .base_index(base_index), .sweep_len(sweep_len),
    .busy(busy), .done(done), .err(err),
    .m_axis_index_tvalid(m_axis_index_tvalid), .m_axis_index_tdata(m_axis_index_tdata),
    .s_axis_data_tready(s_axis_data_tready), .m_axis_tready(m_axis_tready),
    .s_axis_data_tvalid(s_axis_data_tvalid), .i(i), .q(q),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_i(out_i), .out_q(out_q),
    .out_tlast(out_tlast));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [11:0] ref_i [BL];
  logic [11:0] ref_q [BL];
  int req_q[$], got_i[$], got_q[$], got_l[$];

  // buffer / sink model state
  bit buf_pend; int buf_idx, buf_cnt;
  int cfg_req, cfg_dat, cfg_out;
  int req_wait, req_stall, out_wait, out_stall;
  bit done_pending, exp_done;
  bit prev_itv, prev_itr, prev_otv, prev_otr, prev_ol;
  logic [IB-1:0] prev_itd; logic [11:0] prev_oi, prev_oq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(0, 4)) : cfg;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);            chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);              chk({tag, "_itv"}, m_axis_index_tvalid, 0);
    chk({tag, "_itd"}, m_axis_index_tdata, 0); chk({tag, "_mtr"}, m_axis_tready, 0);
    chk({tag, "_otv"}, out_tvalid, 0);       chk({tag, "_oi"}, out_i, 0);
    chk({tag, "_oq"}, out_q, 0);             chk({tag, "_ol"}, out_tlast, 0);
  endtask

  task automatic clear_model();
    buf_pend = 0; done_pending = 0; req_wait = 0; out_wait = 0;
    prev_itv = 0; prev_otv = 0;
    s_axis_data_tready = 0; s_axis_data_tvalid = 0; out_tready = 0;
  endtask

  // One clock: check outputs settled after the last edge, then drive inputs for
  // the next edge and record the handshakes that edge will complete.
  task automatic tick();
    @(negedge clk);
    exp_done = done_pending; done_pending = 0;
    chk("done", done, exp_done);
    chk("err_quiet", err, 0);
    if (prev_itv && !prev_itr) begin
      chk("idx_hold_v", m_axis_index_tvalid, 1);
      chk("idx_hold_d", m_axis_index_tdata, prev_itd);
    end
    if (prev_otv && !prev_otr) begin
      chk("out_hold_v", out_tvalid, 1); chk("out_hold_i", out_i, prev_oi);
      chk("out_hold_q", out_q, prev_oq); chk("out_hold_l", out_tlast, prev_ol);
    end
    if (m_axis_index_tvalid) chk("idx_range", m_axis_index_tdata < BL, 1);
    chk("one_outstanding", m_axis_index_tvalid && (out_tvalid || m_axis_tready), 0);
    // returned data
    if (buf_pend) begin
      if (buf_cnt == 0) begin
        s_axis_data_tvalid = 1; i = ref_i[buf_idx]; q = ref_q[buf_idx];
        if (m_axis_tready) buf_pend = 0;
      end else begin
        buf_cnt--; s_axis_data_tvalid = 0;
      end
    end else begin
      // stray valid outside WAIT must be ignored
      s_axis_data_tvalid = $urandom_range(0, 1); i = 12'($urandom); q = 12'($urandom);
    end
    // index acceptance
    if (m_axis_index_tvalid) begin
      s_axis_data_tready = (req_wait >= req_stall);
      if (s_axis_data_tready) begin
        req_q.push_back(int'(m_axis_index_tdata));
        buf_pend = 1; buf_idx = int'(m_axis_index_tdata) % BL; buf_cnt = pick(cfg_dat);
        req_wait = 0; req_stall = pick(cfg_req);
      end else req_wait++;
    end else s_axis_data_tready = 0;
    // output sink
    if (out_tvalid) begin
      out_tready = (out_wait >= out_stall);
      if (out_tready) begin
        got_i.push_back(int'(out_i)); got_q.push_back(int'(out_q)); got_l.push_back(int'(out_tlast));
        done_pending = out_tlast; out_wait = 0; out_stall = pick(cfg_out);
      end else out_wait++;
    end else out_tready = $urandom_range(0, 1);
    prev_itv = m_axis_index_tvalid; prev_itr = s_axis_data_tready; prev_itd = m_axis_index_tdata;
    prev_otv = out_tvalid; prev_otr = out_tready; prev_oi = out_i; prev_oq = out_q; prev_ol = out_tlast;
  endtask

  task automatic run_sweep(input int b, input int l, input int rq, input int dt, input int ot,
                           input bit inject);
    int eff, first_out, n, idx;
    bit saw_done;
    cfg_req = rq; cfg_dat = dt; cfg_out = ot;
    req_stall = pick(rq); out_stall = pick(ot);
    req_q.delete(); got_i.delete(); got_q.delete(); got_l.delete();
    eff = (l == 0) ? BL : l;
    start = 1; base_index = IB'(b); sweep_len = IB'(l);
    tick();
    start = 0; base_index = IB'($urandom); sweep_len = IB'($urandom);
    chk("busy_after_start", busy, 1);
    first_out = out_tvalid ? 1 : 0;
    saw_done = 0;
    for (n = 2; n < 400 && !saw_done; n++) begin
      if (inject && n == 6) begin start = 1; base_index = 5; sweep_len = 3; end
      if (inject && n == 7) start = 0;
      tick();
      if (out_tvalid && first_out == 0) first_out = n;
      chk("busy_during", busy, 1);
      if (done) saw_done = 1;
    end
    start = 0;
    chk("sweep_timeout", saw_done, 1);
    chk("first_latency", first_out >= 3, 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("req_count", req_q.size(), eff);
    chk("out_count", got_i.size(), eff);
    for (int k = 0; k < eff; k++) begin
      idx = (b + k) % BL;
      if (k < req_q.size()) chk("req_idx", req_q[k], idx);
      if (k < got_i.size()) begin
        chk("out_i", got_i[k], int'(ref_i[idx]));
        chk("out_q", got_q[k], int'(ref_q[idx]));
        chk("out_last", got_l[k], (k == eff - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    n_reset = 0; start = 0; base_index = 0; sweep_len = 0;
    i = 0; q = 0; cfg_req = 0; cfg_dat = 0; cfg_out = 0;
    clear_model();
    for (int k = 0; k < BL; k++) begin ref_i[k] = 12'(k * 10); ref_q[k] = 12'(k * 10); end
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    n_reset = 1;
    tick(); tick();
    chk("idle_out_tvalid", out_tvalid, 0);

    run_sweep(0, 4, 0, 0, 0, 0);
    run_sweep(6, 4, 0, 0, 0, 0);
    run_sweep(1, 3, 0, 0, 5, 0);
    run_sweep(3, 3, 4, 3, 0, 0);

    for (int k = 0; k < BL; k++) begin ref_i[k] = 12'($urandom); ref_q[k] = 12'($urandom); end
    run_sweep(0, 0, 0, 0, 0, 0);

    // invalid base values
    for (int t = 0; t < 2; t++) begin
      start = 1; base_index = (t == 0) ? IB'(8) : IB'($urandom_range(8, 255)); sweep_len = 2;
      @(negedge clk);
      start = 0;
      chk("err_pulse", err, 1); chk("err_busy", busy, 0); chk("err_noreq", m_axis_index_tvalid, 0);
      @(negedge clk);
      chk("err_clear", err, 0); chk("err_busy2", busy, 0); chk("err_noreq2", m_axis_index_tvalid, 0);
    end

    run_sweep(5, 5, -1, -1, -1, 1);
    for (int t = 0; t < 6; t++)
      run_sweep($urandom_range(0, BL - 1), $urandom_range(0, BL), -1, -1, -1, 0);

    // reset while the 2nd sample is in flight
    cfg_req = 0; cfg_dat = 2; cfg_out = 0; req_stall = 0; out_stall = 0;
    req_q.delete(); got_i.delete(); got_q.delete(); got_l.delete();
    start = 1; base_index = 0; sweep_len = 4;
    tick();
    start = 0;
    for (int n = 0; n < 100 && req_q.size() < 2; n++) tick();
    chk("rst_reached_2nd", req_q.size(), 2);
    n_reset = 0;
    @(negedge clk);
    check_zero("midrst");
    n_reset = 1;
    clear_model();
    run_sweep(2, 2, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
